// File: rtl/ball_stepper_pkg.sv
// Shared constants, state/direction encodings and helpers for the ball stepper.
package ball_stepper_pkg;

  localparam int BS_X_W        = 8;
  localparam int BS_Y_W        = 7;
  localparam int BS_X_MAX      = 159;
  localparam int BS_Y_MAX      = 119;
  localparam int BS_L_PAD_X    = 4;
  localparam int BS_R_PAD_X    = 155;
  localparam int BS_PAD_H      = 16;
  localparam int BS_START_X    = 80;
  localparam int BS_START_Y    = 60;
  localparam int BS_HOLD_STEPS = 32;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_DOWN  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MOVE   = 2'd1,
    S_SCORED = 2'd2
  } state_t;

  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? 2'd3 : v + 2'd1;
  endfunction

endpackage

// File: rtl/ball_stepper_rise_edge_det.sv
// Rising-edge detector: one flop plus gate; the flop tracks d regardless of en.
module rise_edge_det (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  input  logic i_d,
  output logic o_pulse
);

  logic r_q;

  // previous-sample register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_q <= 1'b0;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_pulse = i_d & ~r_q & i_en;

endmodule

// File: rtl/ball_stepper.sv
// Ball position stepper: moves the ball one pixel per timer period, bounces, scores.
// Optional macro BALL_SPEEDUP_EN enables the paddle-hit speed selector.
module ball_stepper
  import ball_stepper_pkg::*;
#(
  parameter int X_W        = BS_X_W,
  parameter int Y_W        = BS_Y_W,
  parameter int X_MAX      = BS_X_MAX,
  parameter int Y_MAX      = BS_Y_MAX,
  parameter int L_PAD_X    = BS_L_PAD_X,
  parameter int R_PAD_X    = BS_R_PAD_X,
  parameter int PAD_H      = BS_PAD_H,
  parameter int START_X    = BS_START_X,
  parameter int START_Y    = BS_START_Y,
  parameter int HOLD_STEPS = BS_HOLD_STEPS
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_time_up,
  input  logic           i_enable,
  input  logic           i_serve,
  input  logic           i_serve_dir,
  input  logic [Y_W-1:0] i_pad_l_y,
  input  logic [Y_W-1:0] i_pad_r_y,
  output logic [X_W-1:0] o_ball_x,
  output logic [Y_W-1:0] o_ball_y,
  output logic           o_moving,
  output logic           o_step,
  output logic           o_score_l,
  output logic           o_score_r,
  output logic [1:0]     o_speed_sel
);

  localparam int HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam int YE_W   = Y_W + 1;

  state_t              r_state, w_state_nxt;
  logic [X_W-1:0]      r_x, w_x_nxt;
  logic [Y_W-1:0]      r_y, w_y_nxt;
  logic                r_dx, w_dx_nxt, r_dy, w_dy_nxt;
  logic [HOLD_W-1:0]   r_hold, w_hold_nxt;
  logic                r_moving, r_step, r_score_l, r_score_r;
  logic                w_edge, w_hit, w_step_out, w_score_l, w_score_r;
  logic                w_in_pad_l, w_in_pad_r;
  logic [YE_W-1:0]     w_y_ext, w_pad_l_bot, w_pad_r_bot;

  rise_edge_det u_tu_edge (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (i_enable),
    .i_d     (i_time_up),
    .o_pulse (w_edge)
  );

  // one extra bit keeps pad+PAD_H-1 from wrapping past the bottom row
  assign w_y_ext     = {1'b0, r_y};
  assign w_pad_l_bot = {1'b0, i_pad_l_y} + YE_W'(PAD_H - 1);
  assign w_pad_r_bot = {1'b0, i_pad_r_y} + YE_W'(PAD_H - 1);
  assign w_in_pad_l  = (w_y_ext >= {1'b0, i_pad_l_y}) && (w_y_ext <= w_pad_l_bot);
  assign w_in_pad_r  = (w_y_ext >= {1'b0, i_pad_r_y}) && (w_y_ext <= w_pad_r_bot);

  // next-state and next-position logic
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_dx_nxt    = r_dx;
    w_dy_nxt    = r_dy;
    w_hold_nxt  = r_hold;
    w_hit       = 1'b0;
    w_score_l   = 1'b0;
    w_score_r   = 1'b0;
    w_step_out  = w_edge;
    case (r_state)
      S_IDLE: begin
        if (i_serve && i_enable) begin
          w_state_nxt = S_MOVE;
          w_dx_nxt    = i_serve_dir;
          w_dy_nxt    = DIR_DOWN;
          w_step_out  = 1'b0;
        end else begin
          w_x_nxt = X_W'(START_X);
          w_y_nxt = Y_W'(START_Y);
        end
      end
      S_MOVE: begin
        if (w_edge) begin
          if (r_dy == DIR_DOWN) begin
            if (r_y == Y_W'(Y_MAX)) begin
              w_dy_nxt = DIR_UP;
              w_y_nxt  = r_y - Y_W'(1);
            end else begin
              w_y_nxt  = r_y + Y_W'(1);
            end
          end else begin
            if (r_y == Y_W'(0)) begin
              w_dy_nxt = DIR_DOWN;
              w_y_nxt  = r_y + Y_W'(1);
            end else begin
              w_y_nxt  = r_y - Y_W'(1);
            end
          end
          if (r_dx == DIR_RIGHT) begin
            if ((r_x == X_W'(R_PAD_X - 1)) && w_in_pad_r) begin
              w_dx_nxt = DIR_LEFT;
              w_x_nxt  = r_x - X_W'(1);
              w_hit    = 1'b1;
            end else if (r_x == X_W'(X_MAX)) begin
              w_score_l   = 1'b1;
              w_state_nxt = S_SCORED;
            end else begin
              w_x_nxt = r_x + X_W'(1);
            end
          end else begin
            if ((r_x == X_W'(L_PAD_X + 1)) && w_in_pad_l) begin
              w_dx_nxt = DIR_RIGHT;
              w_x_nxt  = r_x + X_W'(1);
              w_hit    = 1'b1;
            end else if (r_x == X_W'(0)) begin
              w_score_r   = 1'b1;
              w_state_nxt = S_SCORED;
            end else begin
              w_x_nxt = r_x - X_W'(1);
            end
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_SCORED: begin
        if (w_edge) begin
          if (r_hold == HOLD_W'(HOLD_STEPS - 1)) begin
            w_hold_nxt  = HOLD_W'(0);
            w_x_nxt     = X_W'(START_X);
            w_y_nxt     = Y_W'(START_Y);
            w_state_nxt = S_IDLE;
          end else begin
            w_hold_nxt = r_hold + HOLD_W'(1);
          end
        end else begin
          w_hold_nxt = r_hold;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // state, position and pulse registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_x       <= X_W'(START_X);
      r_y       <= Y_W'(START_Y);
      r_dx      <= DIR_LEFT;
      r_dy      <= DIR_DOWN;
      r_hold    <= HOLD_W'(0);
      r_moving  <= 1'b0;
      r_step    <= 1'b0;
      r_score_l <= 1'b0;
      r_score_r <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_x       <= w_x_nxt;
      r_y       <= w_y_nxt;
      r_dx      <= w_dx_nxt;
      r_dy      <= w_dy_nxt;
      r_hold    <= w_hold_nxt;
      r_moving  <= (w_state_nxt == S_MOVE);
      r_step    <= w_step_out;
      r_score_l <= w_score_l;
      r_score_r <= w_score_r;
    end
  end

`ifdef BALL_SPEEDUP_EN
  logic [1:0] r_speed;

  // paddle-hit speed selector, cleared when a point is scored
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_speed <= 2'd0;
    end else if ((w_state_nxt == S_SCORED) && (r_state != S_SCORED)) begin
      r_speed <= 2'd0;
    end else if (w_hit) begin
      r_speed <= sat_inc2(r_speed);
    end else begin
      r_speed <= r_speed;
    end
  end

  assign o_speed_sel = r_speed;
`else
  logic w_unused_hit;
  assign w_unused_hit = w_hit;
  assign o_speed_sel  = 2'd0;
`endif

  assign o_ball_x  = r_x;
  assign o_ball_y  = r_y;
  assign o_moving  = r_moving;
  assign o_step    = r_step;
  assign o_score_l = r_score_l;
  assign o_score_r = r_score_r;

endmodule

// File: tb/tb_ball_stepper.sv
// Scoreboard bench for ball_stepper: a reference model predicts every step result.
module tb_ball_stepper;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       time_up = 1'b0;
  logic       enable = 1'b1;
  logic       serve = 1'b0;
  logic       serve_dir = 1'b0;
  logic [6:0] pad_l_y = 7'd0;
  logic [6:0] pad_r_y = 7'd0;
  logic [7:0] ball_x;
  logic [6:0] ball_y;
  logic       moving, step, score_l, score_r;
  logic [1:0] speed_sel;

  ball_stepper dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_time_up   (time_up),
    .i_enable    (enable),
    .i_serve     (serve),
    .i_serve_dir (serve_dir),
    .i_pad_l_y   (pad_l_y),
    .i_pad_r_y   (pad_r_y),
    .o_ball_x    (ball_x),
    .o_ball_y    (ball_y),
    .o_moving    (moving),
    .o_step      (step),
    .o_score_l   (score_l),
    .o_score_r   (score_r),
    .o_speed_sel (speed_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x; int y; bit sl; bit sr; int spd; bit mv;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_steps_seen = 0;

  // reference model: 0=IDLE 1=MOVE 2=SCORED
  int m_state, m_x, m_y, m_dx, m_dy, m_hold, m_speed, m_hits;

`ifdef BALL_SPEEDUP_EN
  localparam int SPEEDUP = 1;
`else
  localparam int SPEEDUP = 0;
`endif

  task automatic model_reset();
    m_state = 0; m_x = 80; m_y = 60; m_dx = 0; m_dy = 1;
    m_hold = 0; m_speed = 0;
  endtask

  task automatic model_step();
    exp_t e;
    int px, py, top;
    e.sl = 1'b0; e.sr = 1'b0;
    px = m_x; py = m_y;
    if (m_state == 1) begin
      if (m_dy == 1) begin
        if (py == 119) begin m_dy = 0; m_y = 118; end
        else m_y = py + 1;
      end else begin
        if (py == 0) begin m_dy = 1; m_y = 1; end
        else m_y = py - 1;
      end
      if (m_dx == 1) begin
        top = int'(pad_r_y);
        if (px == 154 && py >= top && py <= top + 15) begin
          m_dx = 0; m_x = px - 1; m_hits++;
          if (SPEEDUP == 1 && m_speed < 3) m_speed++;
        end else if (px == 159) begin
          e.sl = 1'b1; m_state = 2; m_speed = 0;
        end else m_x = px + 1;
      end else begin
        top = int'(pad_l_y);
        if (px == 5 && py >= top && py <= top + 15) begin
          m_dx = 1; m_x = px + 1; m_hits++;
          if (SPEEDUP == 1 && m_speed < 3) m_speed++;
        end else if (px == 0) begin
          e.sr = 1'b1; m_state = 2; m_speed = 0;
        end else m_x = px - 1;
      end
    end else if (m_state == 2) begin
      if (m_hold == 31) begin
        m_hold = 0; m_state = 0; m_x = 80; m_y = 60;
      end else m_hold++;
    end
    e.x = m_x; e.y = m_y; e.spd = m_speed; e.mv = (m_state == 1);
    sb.push_back(e);
  endtask

  // scoreboard consumer: every step pulse is matched against the oldest prediction
  always @(negedge clk) begin
    exp_t e;
    if (!reset && step) begin
      n_steps_seen++;
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_step got step=1 want no step (x=%0d y=%0d)", ball_x, ball_y);
      end else begin
        e = sb.pop_front();
        if (ball_x !== 8'(e.x) || ball_y !== 7'(e.y) || score_l !== e.sl ||
            score_r !== e.sr || speed_sel !== 2'(e.spd) || moving !== e.mv) begin
          n_bad++;
          $display("FAIL step_result got x=%0d y=%0d sl=%0b sr=%0b spd=%0d mv=%0b want x=%0d y=%0d sl=%0b sr=%0b spd=%0d mv=%0b",
                   ball_x, ball_y, score_l, score_r, speed_sel, moving,
                   e.x, e.y, e.sl, e.sr, e.spd, e.mv);
        end
      end
    end else if (!reset && (score_l || score_r)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL stray_score got sl=%0b sr=%0b want 0 outside a step", score_l, score_r);
    end
  end

  task automatic do_step();
    @(negedge clk);
    time_up = 1'b1;
    if (enable) model_step();
    repeat (2) @(negedge clk);
    time_up = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL step_latency got %0d pending want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_serve(input logic dir);
    @(negedge clk);
    serve = 1'b1; serve_dir = dir;
    m_state = 1; m_dx = int'(dir); m_dy = 1;
    @(negedge clk);
    serve = 1'b0;
  endtask

  function automatic int clamp0(input int v);
    return (v < 0) ? 0 : v;
  endfunction

  task automatic test_reset();
    model_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      time_up = ~time_up;
      n_cmp++;
      if (ball_x !== 8'd80 || ball_y !== 7'd60 || step !== 1'b0 || score_l !== 1'b0 ||
          score_r !== 1'b0 || moving !== 1'b0 || speed_sel !== 2'd0) begin
        n_bad++;
        $display("FAIL reset_state got x=%0d y=%0d st=%0b sl=%0b sr=%0b mv=%0b spd=%0d want 80 60 0 0 0 0 0",
                 ball_x, ball_y, step, score_l, score_r, moving, speed_sel);
      end
    end
    @(negedge clk);
    time_up = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    do_step();
    n_cmp++;
    if (ball_x !== 8'd80 || ball_y !== 7'd60 || moving !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_no_move got x=%0d y=%0d mv=%0b want 80 60 0", ball_x, ball_y, moving);
    end
  endtask

  task automatic test_serve_steps();
    int s0;
    do_serve(1'b1);
    n_cmp++;
    if (moving !== 1'b1 || ball_x !== 8'd80 || ball_y !== 7'd60) begin
      n_bad++;
      $display("FAIL serve got mv=%0b x=%0d y=%0d want 1 80 60", moving, ball_x, ball_y);
    end
    s0 = n_steps_seen;
    for (int i = 0; i < 5; i++) do_step();
    n_cmp++;
    if (ball_x !== 8'd85 || ball_y !== 7'd65 || n_steps_seen - s0 != 5) begin
      n_bad++;
      $display("FAIL five_steps got x=%0d y=%0d steps=%0d want 85 65 5", ball_x, ball_y, n_steps_seen - s0);
    end
  endtask

  task automatic test_wall_bounce();
    for (int i = 0; i < 100 && m_y != 119; i++) do_step();
    do_step();
    n_cmp++;
    if (ball_x !== 8'd140 || ball_y !== 7'd118) begin
      n_bad++;
      $display("FAIL wall_bounce got x=%0d y=%0d want 140 118", ball_x, ball_y);
    end
    do_step();
    n_cmp++;
    if (ball_y !== 7'd117) begin
      n_bad++;
      $display("FAIL wall_dir_up got y=%0d want 117", ball_y);
    end
  endtask

  task automatic test_paddle_hits();
    int offs[4] = '{0, 15, 7, 2};
    int p;
    m_hits = 0;
    for (int i = 0; i < 1500 && m_hits < 4; i++) begin
      p = clamp0(m_y - offs[m_hits % 4]);
      pad_l_y = 7'(p);
      pad_r_y = 7'(p);
      do_step();
      if (m_hits == 1 && m_x == 153 && m_dx == 0) begin
        n_cmp++;
        if (ball_x !== 8'd153 || speed_sel !== 2'(SPEEDUP)) begin
          n_bad++;
          $display("FAIL first_hit got x=%0d spd=%0d want 153 %0d", ball_x, speed_sel, SPEEDUP);
        end
      end
    end
    n_cmp++;
    if (m_hits != 4 || speed_sel !== 2'(3 * SPEEDUP)) begin
      n_bad++;
      $display("FAIL four_hits got hits=%0d spd=%0d want 4 %0d", m_hits, speed_sel, 3 * SPEEDUP);
    end
  endtask

  task automatic test_miss_right();
    for (int i = 0; i < 600 && m_state != 2; i++) begin
      pad_l_y = 7'(clamp0(m_y - 2));
      pad_r_y = 7'(m_y + 1);
      do_step();
    end
    n_cmp++;
    if (moving !== 1'b0 || ball_x !== 8'd159 || speed_sel !== 2'd0) begin
      n_bad++;
      $display("FAIL miss_right got mv=%0b x=%0d spd=%0d want 0 159 0", moving, ball_x, speed_sel);
    end
    for (int i = 0; i < 31; i++) do_step();
    n_cmp++;
    if (ball_x !== 8'd159 || moving !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_frozen got x=%0d mv=%0b want 159 0", ball_x, moving);
    end
    do_step();
    n_cmp++;
    if (ball_x !== 8'd80 || ball_y !== 7'd60 || moving !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_return got x=%0d y=%0d mv=%0b want 80 60 0", ball_x, ball_y, moving);
    end
  endtask

  task automatic test_enable_pause();
    int s0;
    do_serve(1'b1);
    for (int i = 0; i < 3; i++) do_step();
    enable = 1'b0;
    s0 = n_steps_seen;
    for (int i = 0; i < 10; i++) do_step();
    n_cmp++;
    if (ball_x !== 8'd83 || ball_y !== 7'd63 || n_steps_seen != s0) begin
      n_bad++;
      $display("FAIL paused got x=%0d y=%0d steps=%0d want 83 63 0", ball_x, ball_y, n_steps_seen - s0);
    end
    enable = 1'b1;
    for (int i = 0; i < 2; i++) do_step();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    n_cmp++;
    if (ball_x !== 8'd80 || ball_y !== 7'd60 || moving !== 1'b0 ||
        score_l !== 1'b0 || score_r !== 1'b0 || step !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid got x=%0d y=%0d mv=%0b sl=%0b sr=%0b st=%0b want 80 60 0 0 0 0",
               ball_x, ball_y, moving, score_l, score_r, step);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_miss_left();
    do_serve(1'b0);
    for (int i = 0; i < 300 && m_state != 2; i++) begin
      pad_l_y = 7'(m_y + 1);
      do_step();
    end
    n_cmp++;
    if (moving !== 1'b0 || ball_x !== 8'd0 || m_state != 2) begin
      n_bad++;
      $display("FAIL miss_left got mv=%0b x=%0d want 0 0", moving, ball_x);
    end
  endtask

  initial begin
    test_reset();
    test_serve_steps();
    test_wall_bounce();
    test_paddle_hits();
    test_miss_right();
    test_enable_pause();
    test_reset_mid();
    test_miss_left();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
